// File: rtl/ro_freq_counter_if.sv
// Control/status bundle between a ring-oscillator frequency counter and its controller.
// The master side drives start and gate length and carries the RO output in; the slave side is the counter.
interface ro_freq_counter_if #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
);
    logic              start;
    logic [GATE_W-1:0] gate_cycles;
    logic              osc_in;
    logic              ro_enable;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output start, gate_cycles, osc_in,
        input  ro_enable, busy, done, count, overflow
    );

    modport slave (
        input  start, gate_cycles, osc_in,
        output ro_enable, busy, done, count, overflow
    );
endinterface

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: powers the RO, lets it settle, then counts synchronized
// rising edges over a programmable window of clk_sys cycles. One measurement per start.
//
// state  | meaning
// IDLE   | RO off, waiting for start
// SETTLE | RO on, waiting SETTLE_CYCLES before counting
// GATE   | RO on, counting rising edges for gate_r cycles
// DONE   | RO off, result published, done pulse
module ro_freq_counter #(
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    ro_freq_counter_if.slave   bus
);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [GATE_W-1:0] gate_r;
    logic [CNT_W-1:0]  acc;
    logic              ovf;
    logic [CNT_W-1:0]  acc_nxt;
    logic              ovf_nxt;
    logic              s1, s2, s3;
    logic              rise;
    logic              ro_en_r;
    logic              busy_r;
    logic              done_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;

    // osc_in is asynchronous; s1/s2 resolve metastability, s3 gives the edge reference
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.osc_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Saturating accumulate; ovf marks an edge that arrived while already at all-ones
    always_comb begin
        acc_nxt = acc;
        ovf_nxt = ovf;
        if (rise) begin
            if (acc == '1) begin
                ovf_nxt = 1'b1;
            end else begin
                acc_nxt = acc + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            gate_r     <= '0;
            acc        <= '0;
            ovf        <= 1'b0;
            ro_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        gate_r  <= bus.gate_cycles;
                        acc     <= '0;
                        ovf     <= 1'b0;
                        timer   <= TMR_W'(SETTLE_CYCLES - 1);
                        ro_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer == '0) begin
                        if (gate_r != '0) begin
                            timer <= TMR_W'(gate_r) - TMR_W'(1);
                            state <= GATE;
                        end else begin
                            ro_en_r    <= 1'b0;
                            done_r     <= 1'b1;
                            count_r    <= acc;
                            overflow_r <= ovf;
                            state      <= DONE;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                GATE: begin
                    acc <= acc_nxt;
                    ovf <= ovf_nxt;
                    if (timer == '0) begin
                        // publish the next-state values so the last window cycle's edge is included
                        ro_en_r    <= 1'b0;
                        done_r     <= 1'b1;
                        count_r    <= acc_nxt;
                        overflow_r <= ovf_nxt;
                        state      <= DONE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    ro_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ro_enable = ro_en_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.count     = count_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: scoreboard of expected results per accepted start, popped on done.
// A second instance with a 4-bit counter exercises saturation.
module tb_ro_freq_counter;
    localparam int S = 16;

    typedef struct {
        int unsigned edge_n;
        int unsigned cnt;
        bit          ovf;
        int unsigned en;
    } exp_t;

    logic clk;
    logic rst;
    logic osc;
    int   osc_half;
    logic osc_val;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   dones_a;
    int   dones_b;
    int   en_a, en_b;
    longint last_a, last_b, prev_a, prev_b;
    exp_t qa[$];
    exp_t qb[$];

    ro_freq_counter_if #(.CNT_W(16), .GATE_W(16)) ia ();
    ro_freq_counter_if #(.CNT_W(4),  .GATE_W(16)) ib ();

    assign ia.osc_in = osc;
    assign ib.osc_in = osc;

    ro_freq_counter #(.CNT_W(16), .GATE_W(16), .SETTLE_CYCLES(S)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    ro_freq_counter #(.CNT_W(4), .GATE_W(16), .SETTLE_CYCLES(S)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // osc edges land at 2 mod 10 ns, away from both clk edges, so rise pulses are exactly periodic
    initial begin
        osc = 1'b0;
        #2;
        forever begin
            if (osc_half == 0) begin
                osc = osc_val;
                #10;
            end else begin
                osc = ~osc;
                #(osc_half);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            en_a = 0; last_a = 0; prev_a = 0;
        end else begin
            if (ia.done) begin
                dones_a++;
                if (qa.size() == 0) begin
                    check("spurious_done_a", 1, 0);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    check("done_cycle_a", cyc, e.edge_n);
                    check("count_a", ia.count, e.cnt);
                    check("overflow_a", ia.overflow, e.ovf);
                    check("ro_en_cycles_a", en_a, e.en);
                    check("busy_in_done_a", ia.busy, 1);
                    check("count_hold_a", prev_a, last_a);
                end
                last_a = ia.count;
                en_a = 0;
            end else if (ia.ro_enable) begin
                en_a++;
            end
            prev_a = ia.count;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            en_b = 0; last_b = 0; prev_b = 0;
        end else begin
            if (ib.done) begin
                dones_b++;
                if (qb.size() == 0) begin
                    check("spurious_done_b", 1, 0);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    check("done_cycle_b", cyc, e.edge_n);
                    check("count_b", ib.count, e.cnt);
                    check("overflow_b", ib.overflow, e.ovf);
                    check("ro_en_cycles_b", en_b, e.en);
                    check("count_hold_b", prev_b, last_b);
                end
                last_b = ib.count;
                en_b = 0;
            end else if (ib.ro_enable) begin
                en_b++;
            end
            prev_b = ib.count;
        end
    end

    // Call right after a negedge; start is sampled at the next posedge (edge cyc+1)
    task automatic run_a(input int gate, input int exp_cnt, input bit exp_ovf);
        exp_t e;
        ia.gate_cycles = 16'(gate);
        ia.start = 1'b1;
        e.edge_n = cyc + 1 + S + gate;
        e.cnt = exp_cnt;
        e.ovf = exp_ovf;
        e.en = S + gate;
        qa.push_back(e);
        @(negedge clk);
        ia.start = 1'b0;
    endtask

    task automatic run_b(input int gate, input int exp_cnt, input bit exp_ovf);
        exp_t e;
        ib.gate_cycles = 16'(gate);
        ib.start = 1'b1;
        e.edge_n = cyc + 1 + S + gate;
        e.cnt = exp_cnt;
        e.ovf = exp_ovf;
        e.en = S + gate;
        qb.push_back(e);
        @(negedge clk);
        ib.start = 1'b0;
    endtask

    task automatic wait_a(input int budget);
        for (int i = 0; i < budget && qa.size() != 0; i++) @(negedge clk);
        if (qa.size() != 0) begin
            check("timeout_a", qa.size(), 0);
            qa.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_b(input int budget);
        for (int i = 0; i < budget && qb.size() != 0; i++) @(negedge clk);
        if (qb.size() != 0) begin
            check("timeout_b", qb.size(), 0);
            qb.delete();
        end
        @(negedge clk);
    endtask

    task automatic set_osc(input int period_clk, input logic stuck);
        osc_val = stuck;
        osc_half = period_clk * 5;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int d0;
        int base;
        int per[3];
        int gat[3];

        cyc = 0; n_checks = 0; n_errors = 0; dones_a = 0; dones_b = 0;
        osc_half = 40; osc_val = 1'b0;
        ia.start = 1'b0; ia.gate_cycles = '0;
        ib.start = 1'b0; ib.gate_cycles = '0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_busy_a", ia.busy, 0);
        check("rst_ro_en_a", ia.ro_enable, 0);
        check("rst_count_a", ia.count, 0);
        check("rst_done_b", ib.done, 0);
        #3 rst = 1'b0;
        repeat (5) @(negedge clk);

        // Frequency estimates: count = gate / period exactly when gate is a multiple of period
        per[0] = 8; gat[0] = 64;
        per[1] = 4; gat[1] = 32;
        per[2] = 8; gat[2] = 40;
        for (int k = 0; k < 3; k++) begin
            set_osc(per[k], 1'b0);
            run_a(gat[k], gat[k] / per[k], 1'b0);
            wait_a(400);
        end

        // Zero-length window
        run_a(0, 0, 1'b0);
        wait_a(100);

        // Stuck-high osc and a second start (with a new gate length) during GATE
        set_osc(0, 1'b1);
        d0 = dones_a;
        run_a(64, 0, 1'b0);
        repeat (S + 10) @(negedge clk);
        check("busy_mid_gate_a", ia.busy, 1);
        ia.start = 1'b1;
        ia.gate_cycles = 16'd3;
        @(negedge clk);
        ia.start = 1'b0;
        wait_a(400);
        repeat (40) @(negedge clk);
        check("single_done_a", dones_a - d0, 1);

        // Saturation on the 4-bit instance, then recovery
        set_osc(4, 1'b0);
        run_b(100, 15, 1'b1);
        wait_b(400);
        run_b(8, 2, 1'b0);
        wait_b(200);

        // start held high: back-to-back runs spaced 1+S+N+1 cycles
        set_osc(8, 1'b0);
        d0 = dones_a;
        ia.gate_cycles = 16'd16;
        ia.start = 1'b1;
        base = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.edge_n = base + S + 16 + k * (S + 16 + 2);
            e.cnt = 2;
            e.ovf = 1'b0;
            e.en = S + 16;
            qa.push_back(e);
        end
        for (int i = 0; i < 400 && qa.size() != 0; i++) @(negedge clk);
        ia.start = 1'b0;
        if (qa.size() != 0) begin
            check("timeout_b2b_a", qa.size(), 0);
            qa.delete();
        end
        repeat (60) @(negedge clk);
        check("b2b_done_count_a", dones_a - d0, 3);

        // Reset in the middle of GATE discards the measurement
        run_a(64, 8, 1'b0);
        repeat (S + 20) @(negedge clk);
        check("pre_rst_count_a", ia.count, 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ro_en_a", ia.ro_enable, 0);
        check("mid_rst_busy_a", ia.busy, 0);
        check("mid_rst_done_a", ia.done, 0);
        check("mid_rst_count_a", ia.count, 0);
        check("mid_rst_overflow_b", ib.overflow, 0);
        qa.delete();
        @(negedge clk);
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy_a", ia.busy, 0);
        check("post_rst_count_a", ia.count, 0);
        run_a(8, 1, 1'b0);
        wait_a(100);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
